cordic_neuron_sequencer: RTL and testbench
==========================================

Name: cordic_neuron_sequencer

Overview:
Sequences the reconfigurable CORDIC MAC/activation core (recon_top_level) to evaluate one neuron: acc = bias + sum(x_i*w_i), then an optional activation pass. Holds a small operand buffer loaded by the host, issues one core operation per term, waits the fixed CORDIC latency, and chains each accumulation into the next issue (Xo=x_i, Zo=w_i, Yo=acc). Sits between the layer controller/host and a single recon_top_level instance.

Parameters:
WIDTH, 15, MSB index; all data buses are WIDTH+1 bits, signed Q5.10 (1.0 = 0x0400)
DEPTH, 16, operand buffer entries (power of two)
ADDR_W, 4, log2(DEPTH)
CORE_LAT, 35, cycles from core_reset deassertion to valid core output
SEL_MAC, 2'b00, core sel code for MAC mode
SEL_ACT, 2'b00, core sel code for activation pass
ACT_X0, 16'h0400, core_Xo driven during activation pass

Ports:
clk  in  1  clock
ext_reset  in  1  synchronous active-high reset
wr_en  in  1  operand write strobe (honoured only in IDLE)
wr_addr  in  ADDR_W  operand buffer index
wr_x  in  WIDTH+1  input activation x
wr_w  in  WIDTH+1  weight w
bias  in  WIDTH+1  initial accumulator, sampled on start
num_terms  in  ADDR_W+1  terms to accumulate, sampled on start; values >DEPTH clamp to DEPTH
act_en  in  1  run activation pass, sampled on start
start  in  1  begin neuron evaluation (honoured only in IDLE)
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse, result valid
result  out  WIDTH+1  final value, held until next accepted start
core_Xo, core_Yo, core_Zo  out  WIDTH+1 each  core operands
core_reset  out  1  core restart (high = core held in reset)
core_sel  out  2  core mode
core_af_en  out  1  core activation enable
core_mac_out  in  WIDTH+1  core MAC result
core_z  in  WIDTH+1  core activation result

Behaviour:
- Reset (sync, and any time mid-operation): state IDLE; busy=0, done=0, result=0, acc=0, idx=0, core_reset=1, core_af_en=0, core_sel=SEL_MAC, core operands 0. Buffer contents are not cleared.
- States: IDLE, ISSUE, WAIT, CAPTURE, ACT_ISSUE, ACT_WAIT, ACT_CAPTURE, DONE.
- IDLE: wr_en writes {x,w} at wr_addr. On start: latch bias->acc, N=min(num_terms,DEPTH), act_en; idx=0; next state ISSUE if N>0, else ACT_ISSUE if act_en, else DONE. start and wr_en in the same cycle: the write completes first and is visible to the run.
- ISSUE (1 cycle): core_reset=1, core_Xo=x[idx], core_Zo=w[idx], core_Yo=acc, core_sel=SEL_MAC, core_af_en=0.
- WAIT: core_reset=0, operands held; counter runs CORE_LAT cycles, then CAPTURE.
- CAPTURE (1 cycle): acc<=core_mac_out; if idx==N-1 go ACT_ISSUE (act_en) or DONE; else idx++, ISSUE. Cost per term = CORE_LAT+2 cycles.
- ACT_ISSUE/ACT_WAIT/ACT_CAPTURE: same timing; core_Xo=ACT_X0, core_Yo=0, core_Zo=acc, core_sel=SEL_ACT, core_af_en=1; capture acc<=core_z.
- DONE (1 cycle): result<=acc (registered), done=1, busy=0 next cycle; return IDLE with core_reset=1.
- Latency: with start sampled at edge 0, done is high during cycle (N + act_en)*(CORE_LAT+2) + 1.
- start or wr_en while busy: ignored, no side effects. No saturation is added here; the core's arithmetic is passed through unchanged.

Test Plan:
- Bench core model: after CORE_LAT cycles with core_reset low, mac_out=Yo+((Xo*Zo)>>>10); z=f(Zo) lookup.
- Single term: x[0]=0x0200 (0.5), w[0]=0x0100 (0.25), bias=0, N=1, act_en=0 -> done at cycle 38, result=0x0080, busy high cycles 1..37.
- Chained: x={0x0400,0x0200,0xFE00}, w={0x0200,0x0400,0x0100}, bias=0x0100, N=3 -> result=0x0100+0x0200+0x0200-0x0080=0x0480, done at cycle 112.
- Activation: same as single term, act_en=1 -> second issue with core_Zo=0x0080, core_af_en=1, core_Xo=0x0400; result=f(0x0080), done at cycle 75.
- Edge cases: N=0, act_en=0 -> result=bias, done at cycle 1; num_terms=20 -> exactly 16 issues.
- Reset mid-WAIT on term 2 -> next cycle IDLE, busy=0, core_reset=1, no done. start and wr_en while busy -> ignored; buffer and result unchanged.

Source files
------------

// File: rtl/cordic_neuron_sequencer.sv
// Sequences one recon_top_level CORDIC core through a neuron evaluation:
// acc = bias + sum(x_i*w_i), then an optional activation pass.
module cordic_neuron_sequencer #(
  parameter int               WIDTH    = 15,
  parameter int               DEPTH    = 16,
  parameter int               ADDR_W   = 4,
  parameter int               CORE_LAT = 35,
  parameter logic [1:0]       SEL_MAC  = 2'b00,
  parameter logic [1:0]       SEL_ACT  = 2'b00,
  parameter logic [WIDTH:0]   ACT_X0   = 'h0400
) (
  input  logic              clk,
  input  logic              ext_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH:0]    wr_x,
  input  logic [WIDTH:0]    wr_w,
  input  logic [WIDTH:0]    bias,
  input  logic [ADDR_W:0]   num_terms,
  input  logic              act_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    result,
  output logic [WIDTH:0]    core_Xo,
  output logic [WIDTH:0]    core_Yo,
  output logic [WIDTH:0]    core_Zo,
  output logic              core_reset,
  output logic [1:0]        core_sel,
  output logic              core_af_en,
  input  logic [WIDTH:0]    core_mac_out,
  input  logic [WIDTH:0]    core_z
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE,
    S_ACT_ISSUE, S_ACT_WAIT, S_ACT_CAPTURE, S_DONE
  } state_t;

  localparam int              CNT_W   = $clog2(CORE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CORE_LAT - 1);
  localparam logic [ADDR_W:0]  DEPTH_N = (ADDR_W + 1)'(DEPTH);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH:0]      acc;
  logic [ADDR_W:0]     n_terms;
  logic                act_q;
  logic [ADDR_W-1:0]   idx;
  logic [WIDTH:0]      x_mem [DEPTH];
  logic [WIDTH:0]      w_mem [DEPTH];

  logic [ADDR_W:0]     n_clamp;
  logic [ADDR_W-1:0]   idx_next;
  logic                last_term;
  logic [WIDTH:0]      x_first;
  logic [WIDTH:0]      w_first;

  assign n_clamp   = (num_terms > DEPTH_N) ? DEPTH_N : num_terms;
  assign idx_next  = idx + 1'b1;
  assign last_term = ({1'b0, idx} == n_terms - 1'b1);
  // A write in the same cycle as start must be seen by the first issue.
  assign x_first   = (wr_en && wr_addr == '0) ? wr_x : x_mem[0];
  assign w_first   = (wr_en && wr_addr == '0) ? wr_w : w_mem[0];

  // NOTE: the operand buffer has no reset so it maps onto plain RAM; contents survive ext_reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && wr_en) begin
      x_mem[wr_addr] <= wr_x;
      w_mem[wr_addr] <= wr_w;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (ext_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      n_terms    <= '0;
      act_q      <= 1'b0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      core_Xo    <= '0;
      core_Yo    <= '0;
      core_Zo    <= '0;
      core_reset <= 1'b1;
      core_sel   <= SEL_MAC;
      core_af_en <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc     <= bias;
            n_terms <= n_clamp;
            act_q   <= act_en;
            idx     <= '0;
            if (n_clamp != '0) begin
              state      <= S_ISSUE;
              busy       <= 1'b1;
              core_reset <= 1'b1;
              core_Xo    <= x_first;
              core_Zo    <= w_first;
              core_Yo    <= bias;
              core_sel   <= SEL_MAC;
              core_af_en <= 1'b0;
            end else if (act_en) begin
              state      <= S_ACT_ISSUE;
              busy       <= 1'b1;
              core_reset <= 1'b1;
              core_Xo    <= ACT_X0;
              core_Yo    <= '0;
              core_Zo    <= bias;
              core_sel   <= SEL_ACT;
              core_af_en <= 1'b1;
            end else begin
              state  <= S_DONE;
              result <= bias;
              done   <= 1'b1;
            end
          end
        end
        S_ISSUE, S_ACT_ISSUE: begin
          core_reset <= 1'b0;
          cnt        <= '0;
          state      <= (state == S_ISSUE) ? S_WAIT : S_ACT_WAIT;
        end
        S_WAIT, S_ACT_WAIT: begin
          if (cnt == CNT_END) begin
            state <= (state == S_WAIT) ? S_CAPTURE : S_ACT_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          acc        <= core_mac_out;
          core_reset <= 1'b1;
          if (!last_term) begin
            idx     <= idx_next;
            state   <= S_ISSUE;
            core_Xo <= x_mem[idx_next];
            core_Zo <= w_mem[idx_next];
            core_Yo <= core_mac_out;
          end else if (act_q) begin
            state      <= S_ACT_ISSUE;
            core_Xo    <= ACT_X0;
            core_Yo    <= '0;
            core_Zo    <= core_mac_out;
            core_sel   <= SEL_ACT;
            core_af_en <= 1'b1;
          end else begin
            state  <= S_DONE;
            result <= core_mac_out;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        S_ACT_CAPTURE: begin
          acc        <= core_z;
          result     <= core_z;
          done       <= 1'b1;
          busy       <= 1'b0;
          core_reset <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          done       <= 1'b0;
          core_reset <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_neuron_sequencer.sv
// Self-checking bench: behavioural CORDIC core stand-in plus a plain-arithmetic
// neuron reference model; directed and randomized neuron evaluations.
module tb_cordic_neuron_sequencer;

  localparam int CORE_LAT = 35;
  localparam int TERM_CYC = CORE_LAT + 2;

  logic        clk = 1'b0;
  logic        ext_reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_x, wr_w, bias;
  logic [4:0]  num_terms;
  logic        act_en, start;
  logic        busy, done;
  logic [15:0] result;
  logic [15:0] core_Xo, core_Yo, core_Zo;
  logic        core_reset;
  logic [1:0]  core_sel;
  logic        core_af_en;
  logic [15:0] core_mac_out, core_z;

  int checks = 0;
  int failures = 0;

  logic [15:0] bx [16];
  logic [15:0] bw [16];
  logic [15:0] prev_result;

  always #5 clk = ~clk;

  cordic_neuron_sequencer dut (
    .clk(clk), .ext_reset(ext_reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_w(wr_w), .bias(bias), .num_terms(num_terms),
    .act_en(act_en), .start(start), .busy(busy), .done(done), .result(result),
    .core_Xo(core_Xo), .core_Yo(core_Yo), .core_Zo(core_Zo),
    .core_reset(core_reset), .core_sel(core_sel), .core_af_en(core_af_en),
    .core_mac_out(core_mac_out), .core_z(core_z)
  );

  function automatic logic [15:0] mul_q10(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[25:10];
  endfunction

  // Activation lookup stand-in for the core's f(): 0.25*v + 0.5
  function automatic logic [15:0] act_f(input logic [15:0] v);
    return 16'($signed(v) >>> 2) + 16'h0200;
  endfunction

  // Core stand-in: result becomes valid CORE_LAT cycles after core_reset drops.
  int core_cnt;
  always @(posedge clk) begin
    if (core_reset) core_cnt <= 0;
    else if (core_cnt < CORE_LAT) core_cnt <= core_cnt + 1;
  end
  assign core_mac_out = (core_cnt >= CORE_LAT) ? core_Yo + mul_q10(core_Xo, core_Zo) : 16'h7FFF;
  assign core_z       = (core_cnt >= CORE_LAT) ? act_f(core_Zo) : 16'h7FFE;

  function automatic logic [15:0] ref_neuron(input logic [15:0] b, input int n, input bit a,
                                             output logic [15:0] pre);
    logic [15:0] s;
    s = b;
    for (int i = 0; i < n; i++) s = s + mul_q10(bx[i], bw[i]);
    pre = s;
    return a ? act_f(s) : s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_op(input int addr, input logic [15:0] x, input logic [15:0] w);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_x = x; wr_w = w;
    bx[addr] = x; bw[addr] = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] b, input int nt, input bit a,
                     input bit inject);
    int n, exp_cycle, done_cycle, issues, busy_bad, res_bad;
    logic [15:0] exp_res, exp_pre, act_xo, act_yo, act_zo;
    logic [1:0] act_sel;
    bit act_seen, prev_rst;
    n = (nt > 16) ? 16 : nt;
    exp_res = ref_neuron(b, n, a, exp_pre);
    exp_cycle = (n + int'(a)) * TERM_CYC + 1;
    done_cycle = -1; issues = 0; busy_bad = 0; res_bad = 0; act_seen = 0; prev_rst = 1'b1;
    act_xo = '0; act_yo = '0; act_zo = '0; act_sel = '0;
    @(negedge clk);
    bias = b; num_terms = 5'(nt); act_en = a; start = 1'b1;
    for (int c = 1; c <= exp_cycle + 40 && done_cycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (inject && c == 11) begin start = 1'b0; wr_en = 1'b0; end
      if (core_reset == 1'b0 && prev_rst) begin
        if (!core_af_en) issues++;
        else begin
          act_seen = 1; act_xo = core_Xo; act_yo = core_Yo; act_zo = core_Zo; act_sel = core_sel;
        end
      end
      prev_rst = core_reset;
      if (busy !== (c < exp_cycle)) busy_bad++;
      if (done === 1'b1) done_cycle = c;
      else if (result !== prev_result) res_bad++;
      if (inject && c == 10) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_x = 16'h1234; wr_w = 16'h4321; bias = ~b;
      end
    end
    check({tag, ".done_cycle"}, 32'(done_cycle), 32'(exp_cycle));
    check({tag, ".result"}, {16'h0, result}, {16'h0, exp_res});
    check({tag, ".issues"}, 32'(issues), 32'(n));
    check({tag, ".busy_profile"}, 32'(busy_bad), 32'd0);
    check({tag, ".result_held"}, 32'(res_bad), 32'd0);
    if (a) begin
      check({tag, ".act_seen"}, {31'h0, act_seen}, 32'd1);
      check({tag, ".act_Xo"}, {16'h0, act_xo}, 32'h0400);
      check({tag, ".act_Yo"}, {16'h0, act_yo}, 32'h0);
      check({tag, ".act_Zo"}, {16'h0, act_zo}, {16'h0, exp_pre});
      check({tag, ".act_sel"}, {30'h0, act_sel}, 32'h0);
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'h0, done}, 32'd0);
    check({tag, ".idle_busy"}, {31'h0, busy}, 32'd0);
    check({tag, ".result_after"}, {16'h0, result}, {16'h0, exp_res});
    prev_result = exp_res;
  endtask

  initial begin
    int no_done;
    ext_reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_w = '0;
    bias = '0; num_terms = '0; act_en = 1'b0; start = 1'b0;
    for (int i = 0; i < 16; i++) begin bx[i] = '0; bw[i] = '0; end
    repeat (3) @(negedge clk);
    ext_reset = 1'b0;
    check("rst.busy", {31'h0, busy}, 32'd0);
    check("rst.done", {31'h0, done}, 32'd0);
    check("rst.result", {16'h0, result}, 32'h0);
    check("rst.core_reset", {31'h0, core_reset}, 32'd1);
    check("rst.core_af_en", {31'h0, core_af_en}, 32'd0);
    check("rst.core_sel", {30'h0, core_sel}, 32'd0);
    check("rst.operands", {16'h0, core_Xo | core_Yo | core_Zo}, 32'h0);
    prev_result = 16'h0;

    // Clear the whole buffer so later runs are fully known
    for (int i = 0; i < 16; i++) write_op(i, 16'h0, 16'h0);

    write_op(0, 16'h0200, 16'h0100);
    run("single", 16'h0000, 1, 1'b0, 1'b0);
    check("single.const", {16'h0, result}, 32'h0080);
    run("act", 16'h0000, 1, 1'b1, 1'b0);
    check("act.const", {16'h0, result}, {16'h0, act_f(16'h0080)});

    write_op(0, 16'h0400, 16'h0200);
    write_op(1, 16'h0200, 16'h0400);
    write_op(2, 16'hFE00, 16'h0100);
    run("chain", 16'h0100, 3, 1'b0, 1'b0);
    check("chain.const", {16'h0, result}, 32'h0480);

    run("n0", 16'h0321, 0, 1'b0, 1'b0);
    run("n0_act", 16'h0321, 0, 1'b1, 1'b0);

    // Busy-time start/write must be ignored; rerun proves the buffer is intact
    run("inject", 16'h0040, 1, 1'b0, 1'b1);
    run("inject_after", 16'h0040, 1, 1'b0, 1'b0);

    // Start coincident with a write to entry 0
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_x = 16'h0300; wr_w = 16'h0200;
    bx[0] = 16'h0300; bw[0] = 16'h0200;
    run("wr_start", 16'h0010, 1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) write_op(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    run("clamp20", 16'($urandom_range(0, 65535)), 20, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run($sformatf("rand%0d", k), 16'($urandom_range(0, 65535)), $urandom_range(0, 16),
          1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of term 2's WAIT
    @(negedge clk);
    bias = 16'h0100; num_terms = 5'd3; act_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (44) @(negedge clk);
    check("midrst.in_wait", {30'h0, busy, core_reset}, 32'h2);
    ext_reset = 1'b1;
    @(negedge clk);
    ext_reset = 1'b0;
    check("midrst.busy", {31'h0, busy}, 32'd0);
    check("midrst.core_reset", {31'h0, core_reset}, 32'd1);
    check("midrst.done", {31'h0, done}, 32'd0);
    check("midrst.result", {16'h0, result}, 32'h0);
    no_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done++;
    end
    check("midrst.quiet", 32'(no_done), 32'd0);
    prev_result = 16'h0;
    run("after_rst", 16'h0100, 3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
